// File: rtl/evm_ballot_unit.sv
// Voter-side ballot unit: synchronises and debounces the presiding-officer and
// candidate buttons, enforces one ballot per admin enable, and drives the
// single-cycle admin/vote strobes plus the voter-panel indicators.
module evm_ballot_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic admin_btn,
    input  logic c1_btn,
    input  logic c2_btn,
    output logic admin_pulse,
    output logic vote_c1,
    output logic vote_c2,
    output logic ballot_ready,
    output logic led1,
    output logic led2,
    output logic invalid,
    output logic timeout
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Button index: 0 = admin, 1 = candidate 1, 2 = candidate 2
    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    level_q;
    logic [2:0]    level_prev_q;
    logic [2:0]    press;
    logic [CW-1:0] cnt_q [3];

    typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;
    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    logic cand_ev;
    logic spoiled;
    logic expire;
    logic admin_pulse_d;
    logic vote_c1_d;
    logic vote_c2_d;
    logic ready_d;
    logic led1_d;
    logic led2_d;
    logic invalid_d;
    logic timeout_d;

    assign raw     = {c2_btn, c1_btn, admin_btn};
    assign press   = level_q & ~level_prev_q;
    assign cand_ev = press[1] | press[2];
    // Both candidate levels high means either a simultaneous press or a press
    // while the other button was already held: the ballot is spoiled.
    assign spoiled = level_q[1] & level_q[2];
    assign expire  = (timer_q == TMR_LAST);

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debouncers: accept a level change after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q      <= '0;
            level_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_prev_q <= level_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_q[i] <= sync2_q[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Ballot FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Ballot FSM next-state logic; a vote on the expiry cycle beats the timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (press[0]) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (cand_ev) begin
                    state_d = StDone;
                end else if (expire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values for the registered outputs and the ballot timer
    always_comb begin
        admin_pulse_d = 1'b0;
        vote_c1_d     = 1'b0;
        vote_c2_d     = 1'b0;
        timeout_d     = 1'b0;
        ready_d       = ballot_ready;
        led1_d        = led1;
        led2_d        = led2;
        invalid_d     = invalid;
        timer_d       = timer_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (press[0]) begin
                    admin_pulse_d = 1'b1;
                    led1_d        = 1'b0;
                    led2_d        = 1'b0;
                    invalid_d     = 1'b0;
                    ready_d       = 1'b1;
                    timer_d       = '0;
                end
            end
            StArmed: begin
                timer_d = timer_q + TW'(1);
                if (cand_ev) begin
                    ready_d = 1'b0;
                    if (spoiled) begin
                        invalid_d = 1'b1;
                    end else if (press[1]) begin
                        vote_c1_d = 1'b1;
                        led1_d    = 1'b1;
                    end else begin
                        vote_c2_d = 1'b1;
                        led2_d    = 1'b1;
                    end
                end else if (expire) begin
                    timeout_d = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and timer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            admin_pulse  <= 1'b0;
            vote_c1      <= 1'b0;
            vote_c2      <= 1'b0;
            timeout      <= 1'b0;
            ballot_ready <= 1'b0;
            led1         <= 1'b0;
            led2         <= 1'b0;
            invalid      <= 1'b0;
            timer_q      <= '0;
        end else begin
            admin_pulse  <= admin_pulse_d;
            vote_c1      <= vote_c1_d;
            vote_c2      <= vote_c2_d;
            timeout      <= timeout_d;
            ballot_ready <= ready_d;
            led1         <= led1_d;
            led2         <= led2_d;
            invalid      <= invalid_d;
            timer_q      <= timer_d;
        end
    end

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Bench for evm_ballot_unit: directed scenarios plus randomized button activity,
// checked by a scoreboard fed from a behavioural ballot model.
module tb_evm_ballot_unit;

    localparam int D = 4;
    localparam int T = 64;
    localparam int KADM = 0, KC1 = 1, KC2 = 2, KTO = 3, KINV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] btns = 3'b000;
    logic admin_pulse, vote_c1, vote_c2, ballot_ready, led1, led2, invalid, timeout;
    logic [7:0] outs;

    assign outs = {admin_pulse, vote_c1, vote_c2, ballot_ready, led1, led2, invalid, timeout};

    evm_ballot_unit #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (rst),
        .admin_btn    (btns[0]),
        .c1_btn       (btns[1]),
        .c2_btn       (btns[2]),
        .admin_pulse  (admin_pulse),
        .vote_c1      (vote_c1),
        .vote_c2      (vote_c2),
        .ballot_ready (ballot_ready),
        .led1         (led1),
        .led2         (led2),
        .invalid      (invalid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {int kind; int at;} exp_t;
    exp_t sb[$];

    // Behavioural model state
    int   cyc = 0;
    bit [31:0] hist [3];
    bit   m_level [3];
    bit   m_event [3];
    bit   m_armed;
    int   m_arm_cyc;
    logic m_ready, m_led1, m_led2, m_inv;
    logic prev_inv;

    function automatic void push(input int kind);
        exp_t e;
        e.kind = kind;
        e.at   = cyc;
        sb.push_back(e);
    endfunction

    // Model: a button level changes once the last D synchronised samples all
    // disagree with it; the ballot rules act on presses one cycle later.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                hist[b] = '0; m_level[b] = 0; m_event[b] = 0;
            end
            m_armed = 0; m_ready = 0; m_led1 = 0; m_led2 = 0; m_inv = 0;
            sb.delete();
        end else begin
            if (!m_armed) begin
                if (m_event[0]) begin
                    m_armed = 1; m_arm_cyc = cyc; m_ready = 1;
                    m_led1 = 0; m_led2 = 0; m_inv = 0;
                    push(KADM);
                end
            end else if (m_event[1] || m_event[2]) begin
                m_armed = 0; m_ready = 0;
                if (m_level[1] && m_level[2]) begin
                    m_inv = 1; push(KINV);
                end else if (m_event[1]) begin
                    m_led1 = 1; push(KC1);
                end else begin
                    m_led2 = 1; push(KC2);
                end
            end else if (cyc - m_arm_cyc == T) begin
                m_armed = 0; m_ready = 0; push(KTO);
            end
            for (int b = 0; b < 3; b++) begin
                bit all_diff;
                bit old;
                all_diff = 1;
                hist[b] = {hist[b][30:0], btns[b]};
                for (int j = 2; j <= D + 1; j++) begin
                    if (hist[b][j] == m_level[b]) all_diff = 0;
                end
                old = m_level[b];
                if (all_diff) m_level[b] = ~m_level[b];
                m_event[b] = m_level[b] & ~old;
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT presents an event
    always @(negedge clk) begin
        int n;
        int k;
        exp_t e;
        if (rst) begin
            prev_inv = 0;
            vectors++;
            if (outs !== 8'h00) begin
                miscompares++;
                $display("FAIL reset outputs: got %b, required 00000000", outs);
            end
        end else begin
            n = 0; k = -1;
            if (admin_pulse) begin n++; k = KADM; end
            if (vote_c1) begin n++; k = KC1; end
            if (vote_c2) begin n++; k = KC2; end
            if (timeout) begin n++; k = KTO; end
            if (invalid && !prev_inv) begin n++; k = KINV; end
            prev_inv = invalid;
            if (n > 0) begin
                vectors++;
                if (n > 1) begin
                    miscompares++;
                    $display("FAIL event: %0d events together at cycle %0d, required one", n, cyc);
                    if (sb.size() > 0 && sb[0].at == cyc) e = sb.pop_front();
                end else if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL event: got kind %0d at cycle %0d, required none", k, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != k || e.at != cyc) begin
                        miscompares++;
                        $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at %0d",
                                 k, cyc, e.kind, e.at);
                    end
                end
            end
            if (sb.size() > 0 && sb[0].at <= cyc) begin
                vectors++;
                miscompares++;
                e = sb.pop_front();
                $display("FAIL event: got none at cycle %0d, required kind %0d", cyc, e.kind);
            end
            vectors++;
            if ({ballot_ready, led1, led2, invalid} !== {m_ready, m_led1, m_led2, m_inv}) begin
                miscompares++;
                $display("FAIL indicators: got rdy/l1/l2/inv %b, required %b at cycle %0d",
                         {ballot_ready, led1, led2, invalid}, {m_ready, m_led1, m_led2, m_inv},
                         cyc);
            end
        end
    end

    function automatic logic strobe(input int w);
        case (w)
            KADM:    return admin_pulse;
            KC1:     return vote_c1;
            KC2:     return vote_c2;
            default: return timeout;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // Count falling edges until the chosen strobe is seen
    task automatic lat_check(input string name, input int w, input int want, input int limit);
        int n;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (strobe(w)) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != want) begin
            miscompares++;
            $display("FAIL %s: latency %0d cycles, required %0d", name, n, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bouncy press on the masked buttons, clean hold, then release and settle
    task automatic press(input logic [2:0] mask, input int bounce, input int hold);
        for (int i = 0; i < bounce; i++) begin
            btns = (btns & ~mask) | (3'($urandom) & mask);
            @(negedge clk);
        end
        btns = btns | mask;
        cycles(hold);
        btns = btns & ~mask;
        cycles(10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        chk("reset state", outs, 8'h00);
        rst = 1'b0;
        cycles(2);

        // Admin then candidate 1, clean presses
        btns[0] = 1'b1;
        lat_check("admin_pulse latency", KADM, 7, 20);
        chk("ready after admin", {7'b0, ballot_ready}, 8'd1);
        cycles(3);
        btns[0] = 1'b0;
        cycles(10);
        btns[1] = 1'b1;
        lat_check("vote_c1 latency", KC1, 7, 20);
        chk("led1 after vote", {6'b0, led1, ballot_ready}, 8'b10);
        cycles(3);
        btns[1] = 1'b0;
        cycles(10);

        // Candidate 2 bouncing every 2 cycles, then stable
        press(3'b001, 0, 8);
        for (int i = 0; i < 6; i++) begin
            btns[2] = ~btns[2];
            cycles(2);
        end
        btns[2] = 1'b1;
        lat_check("vote_c2 after bounce", KC2, 7, 30);
        chk("led2 after vote", {6'b0, led2, led1}, 8'b10);
        btns[2] = 1'b0;
        cycles(10);

        // Both candidates together spoil the ballot
        press(3'b001, 0, 8);
        press(3'b110, 0, 12);
        chk("invalid after both", {5'b0, invalid, vote_c1, vote_c2}, 8'b100);
        press(3'b001, 3, 8);
        chk("invalid cleared by admin", {7'b0, invalid}, 8'd0);

        // Presses in DONE are ignored
        press(3'b010, 0, 8);
        press(3'b010, 2, 8);
        press(3'b100, 2, 8);
        chk("led1 held in done", {7'b0, led1}, 8'd1);
        press(3'b001, 0, 8);
        chk("admin clears led1", {6'b0, led1, ballot_ready}, 8'b01);

        // Timeout 64 cycles after ballot_ready rises
        cycles(80);
        btns[0] = 1'b1;
        lat_check("admin before timeout", KADM, 7, 20);
        lat_check("timeout latency", KTO, T, 100);
        btns[0] = 1'b0;
        chk("ready after timeout", {7'b0, ballot_ready}, 8'd0);
        press(3'b010, 0, 8);

        // Reset mid-ballot with candidate 1 held
        press(3'b001, 0, 8);
        btns[1] = 1'b1;
        cycles(2);
        chk("armed before reset", {7'b0, ballot_ready}, 8'd1);
        #2 rst = 1'b1;
        #1 chk("async reset outputs", outs, 8'h00);
        cycles(3);
        rst = 1'b0;
        cycles(20);
        btns[1] = 1'b0;
        cycles(10);

        // Randomized activity
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0, 1: press(3'b001, $urandom_range(0, 10), $urandom_range(6, 15));
                2:    press(3'b010, $urandom_range(0, 10), $urandom_range(6, 15));
                3:    press(3'b100, $urandom_range(0, 10), $urandom_range(6, 15));
                4:    press(3'b110, $urandom_range(0, 6), $urandom_range(6, 15));
                5:    cycles($urandom_range(10, 80));
                default: begin
                    btns[1] = 1'b1;
                    cycles($urandom_range(6, 10));
                    btns[2] = 1'b1;
                    cycles($urandom_range(6, 10));
                    btns = 3'b000;
                    cycles(10);
                end
            endcase
        end

        cycles(100);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected events outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
